adc_channel_scheduler: RTL and testbench
========================================

ADC_CHANNEL_SCHEDULER -- requirements
Module: adc_channel_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of requesting channels, range 2..8.
REQ-002 SHALL have parameter WIDTH, default 8: converter result width.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for adc_done, range 4..255.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, N_CH: per-channel level conversion request, held until that channel's ack.
REQ-007 SHALL have port ack, output, N_CH: one-hot, one-cycle pulse marking service complete for a channel.
REQ-008 SHALL have port adc_start, output, 1: one-cycle start pulse to the SAR converter.
REQ-009 SHALL have port adc_ch, output, clog2(N_CH): analog mux select, stable from adc_start through capture.
REQ-010 SHALL have port adc_done, input, 1: converter completion level.
REQ-011 SHALL have port adc_data, input, WIDTH: converter result, valid while adc_done is high.
REQ-012 SHALL have port result_valid, output, 1: one-cycle pulse qualifying result_ch, result_data and result_err.
REQ-013 SHALL have port result_ch, output, clog2(N_CH): channel of the delivered result.
REQ-014 SHALL have port result_data, output, WIDTH: captured conversion value.
REQ-015 SHALL have port result_err, output, 1: set on timeout.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, START, CONVERT and STORE.
REQ-018 IDLE: with req != 0, the scheduler SHALL pick a channel round-robin, searching upward from last_ch+1 with wrap, latch it into adc_ch, and go to START next cycle; with req == 0 it SHALL stay in IDLE.
REQ-019 START: the scheduler SHALL drive adc_start high for exactly this one cycle, clear the timeout counter, and go to CONVERT.
REQ-020 CONVERT: the counter SHALL increment each cycle while adc_done is low.
REQ-021 CONVERT: when adc_done is sampled high, the scheduler SHALL capture adc_data into result_data, clear result_err, and go to STORE.
REQ-022 CONVERT: when the counter reaches TIMEOUT-1 with adc_done low, the scheduler SHALL load result_data with all ones, set result_err, and go to STORE.
REQ-023 CONVERT: adc_done seen in the same cycle as the timeout terminal count SHALL be a success, not an error.
REQ-024 STORE: the scheduler SHALL assert result_valid and ack[adc_ch] together for one cycle, set last_ch to adc_ch, and return to IDLE.
REQ-025 Latency: with req sampled in IDLE at edge k, adc_start SHALL be high in cycle k+1.
REQ-026 Latency: result_valid SHALL be high in the cycle after the edge that samples adc_done.
REQ-027 A request deasserted mid-service SHALL not abort that service; the result and ack are still delivered.
REQ-028 Requests arriving while busy SHALL be held pending and arbitrated on the next IDLE cycle.
REQ-029 The scheduler SHALL not insert back-to-back starts; minimum spacing between adc_start pulses is 4 cycles.
REQ-030 A requester holding req continuously SHALL wait at most N_CH-1 other services.
REQ-031 adc_done held high across STORE/IDLE SHALL not be taken as completion of the next conversion: a new conversion is accepted only after adc_done is seen low at least once in CONVERT.
REQ-032 result_data, result_ch and result_err SHALL hold their values until the next STORE.

Reset
REQ-033 rst_n low SHALL immediately force the FSM to IDLE, regardless of clk.
REQ-034 rst_n low SHALL clear adc_start, ack, result_valid, result_err, result_data, result_ch, adc_ch, busy and the counter to 0.
REQ-035 rst_n low SHALL set last_ch to N_CH-1, so channel 0 has first priority.
REQ-036 Reset asserted mid-conversion SHALL drop that service with no ack and no result.
REQ-037 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-038 Single request: req=0001, ADC model returns 8'h00 five cycles after start -> one adc_start pulse with adc_ch=0; result_valid with result_ch=0, result_data=8'h00, result_err=0, ack=0001.
REQ-039 All channels requesting: req=1111 held, model returns 8'hFF -> service order 0,1,2,3,0; ack never multi-hot.
REQ-040 Timeout: adc_done tied low -> result_valid exactly 64 cycles after CONVERT entry with result_data=8'hFF and result_err=1; next request serviced normally.
REQ-041 Reset mid-CONVERT: rst_n pulsed low for 3 ns between clock edges -> busy=0 immediately, no ack for that channel, next grant goes to channel 0.
REQ-042 Stale done: adc_done left high after a conversion, second request issued -> second result_valid occurs only after adc_done goes low then high again, with result_data=8'hA5 as returned.

Source files
------------

// File: rtl/adc_channel_scheduler.sv
// adc_channel_scheduler: round-robin arbiter sequencing channel requests through one SAR converter,
// with per-conversion timeout and protection against a stale adc_done level.
module adc_channel_scheduler #(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           req,
    output logic [N_CH-1:0]           ack,
    output logic                      adc_start,
    output logic [$clog2(N_CH)-1:0]   adc_ch,
    input  logic                      adc_done,
    input  logic [WIDTH-1:0]          adc_data,
    output logic                      result_valid,
    output logic [$clog2(N_CH)-1:0]   result_ch,
    output logic [WIDTH-1:0]          result_data,
    output logic                      result_err,
    output logic                      busy
);
    localparam int CW = $clog2(N_CH);
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, CONVERT, STORE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      adc_ch_q, adc_ch_d;
    logic [CW-1:0]      last_ch_q, last_ch_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               low_seen_q, low_seen_d;
    logic [CW-1:0]      res_ch_q, res_ch_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_err_q, res_err_d;
    logic [CW-1:0]      grant;
    logic [CW-1:0]      idx;
    int                 j;

    // Scan from farthest to nearest so the channel closest after last_ch wins.
    always_comb begin
        grant = last_ch_q;
        idx   = '0;
        j     = 0;
        for (int i = N_CH; i >= 1; i--) begin
            j   = (int'(last_ch_q) + i) % N_CH;
            idx = CW'(j);
            if (req[idx]) grant = idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        adc_ch_d   = adc_ch_q;
        last_ch_d  = last_ch_q;
        cnt_d      = cnt_q;
        low_seen_d = low_seen_q;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    adc_ch_d = grant;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d      = '0;
                low_seen_d = 1'b0;
                state_d    = CONVERT;
            end
            CONVERT: begin
                if (!adc_done) low_seen_d = 1'b1;
                // A done level only counts once it has been low during this conversion.
                if (adc_done && low_seen_q) begin
                    res_data_d = adc_data;
                    res_err_d  = 1'b0;
                    res_ch_d   = adc_ch_q;
                    state_d    = STORE;
                end else if (cnt_q == TMAX) begin
                    res_data_d = '1;
                    res_err_d  = 1'b1;
                    res_ch_d   = adc_ch_q;
                    state_d    = STORE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STORE: begin
                last_ch_d = adc_ch_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            adc_ch_q   <= '0;
            last_ch_q  <= CW'(N_CH - 1);
            cnt_q      <= '0;
            low_seen_q <= 1'b0;
            res_ch_q   <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            adc_ch_q   <= adc_ch_d;
            last_ch_q  <= last_ch_d;
            cnt_q      <= cnt_d;
            low_seen_q <= low_seen_d;
            res_ch_q   <= res_ch_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    assign adc_start    = (state_q == START);
    assign result_valid = (state_q == STORE);
    assign busy         = (state_q != IDLE);
    assign ack          = result_valid ? ({{(N_CH-1){1'b0}}, 1'b1} << adc_ch_q) : '0;
    assign adc_ch       = adc_ch_q;
    assign result_ch    = res_ch_q;
    assign result_data  = res_data_q;
    assign result_err   = res_err_q;
endmodule

// File: tb/tb_adc_channel_scheduler.sv
// tb_adc_channel_scheduler: directed vectors plus hand sequences for reset and stale-done behaviour.
module tb_adc_channel_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic       adc_start;
    logic [1:0] adc_ch;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       result_valid;
    logic [1:0] result_ch;
    logic [7:0] result_data;
    logic       result_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_err  = 1'b0;

    typedef struct {
        logic [3:0] req;
        int         delay;
        logic [7:0] data;
        logic [1:0] exp_ch;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[12];

    adc_channel_scheduler #(.N_CH(4), .WIDTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .adc_start(adc_start), .adc_ch(adc_ch), .adc_done(adc_done), .adc_data(adc_data),
        .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
        .result_err(result_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!adc_start && n < 100);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!result_valid && n < 100);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("hold_data", 32'(result_data), 32'(prev_data));
        check("hold_err", 32'(result_err), 32'(prev_err));
        req = v.req;
        wait_start(n);
        check("start_lat", 32'(n), 32'd1);
        check("adc_ch", 32'(adc_ch), 32'(v.exp_ch));
        check("busy", 32'(busy), 32'd1);
        if (v.delay > 0) begin
            repeat (v.delay) @(negedge clk);
            adc_data = v.data;
            adc_done = 1'b1;
        end
        wait_valid(n);
        check("result_lat", 32'(v.delay + n), 32'(v.exp_lat));
        check("result_ch", 32'(result_ch), 32'(v.exp_ch));
        check("result_data", 32'(result_data), 32'(v.exp_data));
        check("result_err", 32'(result_err), 32'(v.exp_err));
        check("ack", 32'(ack), 32'(4'b0001 << v.exp_ch));
        adc_done  = 1'b0;
        prev_data = v.exp_data;
        prev_err  = v.exp_err;
    endtask

    initial begin
        int n;
        //             req    dly data   ch  exp    err lat
        vecs[0]  = '{4'b1111, 3, 8'hFF, 2'd0, 8'hFF, 1'b0, 4};
        vecs[1]  = '{4'b1111, 2, 8'h11, 2'd1, 8'h11, 1'b0, 3};
        vecs[2]  = '{4'b1111, 4, 8'h22, 2'd2, 8'h22, 1'b0, 5};
        vecs[3]  = '{4'b1111, 6, 8'h33, 2'd3, 8'h33, 1'b0, 7};
        vecs[4]  = '{4'b1111, 2, 8'hFF, 2'd0, 8'hFF, 1'b0, 3};
        vecs[5]  = '{4'b0001, 5, 8'h00, 2'd0, 8'h00, 1'b0, 6};
        vecs[6]  = '{4'b0100, 3, 8'h5A, 2'd2, 8'h5A, 1'b0, 4};
        vecs[7]  = '{4'b1000, 0, 8'h00, 2'd3, 8'hFF, 1'b1, 65};
        vecs[8]  = '{4'b0010, 2, 8'h3C, 2'd1, 8'h3C, 1'b0, 3};
        vecs[9]  = '{4'b1010, 4, 8'h96, 2'd3, 8'h96, 1'b0, 5};
        vecs[10] = '{4'b1010, 2, 8'h81, 2'd1, 8'h81, 1'b0, 3};
        vecs[11] = '{4'b0100, 64, 8'h7E, 2'd2, 8'h7E, 1'b0, 65};

        rst_n = 1'b0; req = 4'b0; adc_done = 1'b0; adc_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_start", 32'(adc_start), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_adc_ch", 32'(adc_ch), 32'd0);
        check("rst_result_ch", 32'(result_ch), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a conversion on channel 2.
        @(negedge clk);
        req = 4'b0100;
        wait_start(n);
        check("rmid_ch", 32'(adc_ch), 32'd2);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_ack", 32'(ack), 32'd0);
        check("rmid_data", 32'(result_data), 32'd0);
        req = 4'b0000;
        #2 rst_n = 1'b1;
        prev_data = 8'h00;
        prev_err  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rmid_no_valid", 32'(result_valid), 32'd0);
        end
        run_vec('{4'b0101, 2, 8'h44, 2'd0, 8'h44, 1'b0, 3});

        // Stale done: leave adc_done high after a conversion, then request again.
        @(negedge clk);
        req = 4'b0010;
        wait_start(n);
        check("st1_ch", 32'(adc_ch), 32'd1);
        repeat (2) @(negedge clk);
        adc_data = 8'hC3;
        adc_done = 1'b1;
        wait_valid(n);
        check("st1_lat", 32'(n), 32'd1);
        check("st1_data", 32'(result_data), 32'hC3);
        @(negedge clk);
        req = 4'b1000;
        wait_start(n);
        check("st2_start_lat", 32'(n), 32'd1);
        check("st2_ch", 32'(adc_ch), 32'd3);
        req = 4'b0000;
        repeat (4) begin
            @(negedge clk);
            check("st2_stale_ignored", 32'(result_valid), 32'd0);
        end
        adc_done = 1'b0;
        repeat (2) @(negedge clk);
        adc_data = 8'hA5;
        adc_done = 1'b1;
        wait_valid(n);
        check("st2_lat", 32'(n), 32'd1);
        check("st2_data", 32'(result_data), 32'hA5);
        check("st2_ch_out", 32'(result_ch), 32'd3);
        check("st2_err", 32'(result_err), 32'd0);
        check("st2_ack", 32'(ack), 32'h8);
        adc_done = 1'b0;
        @(negedge clk);
        check("st2_hold", 32'(result_data), 32'hA5);
        check("st2_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
